// File: rtl/alu_regfile_ctrl.sv
// Operand/result sequencer for the combinational 8-bit ALU.
// Holds a 4x8 register file and runs one command at a time over valid/ready.
module alu_regfile_ctrl #(
    parameter logic [3:0] OP_MAX    = 4'b1001,
    parameter logic [3:0] RST_OPSEL = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_ld,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_sa,
    input  logic [1:0] cmd_sb,
    input  logic [1:0] cmd_dst,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_opsel,
    input  logic [7:0] alu_f,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic [1:0] res_dst,
    output logic       res_err,
    input  logic [1:0] rd_sel,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] regs [4];
    logic [1:0] dst_q;
    logic       accept;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign rd_data   = regs[rd_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!cmd_ld && (cmd_op <= OP_MAX)) begin
                        state_nx = EXEC;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            EXEC:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are snapshotted at accept, so a destination aliasing a source sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_opsel <= RST_OPSEL;
            dst_q     <= 2'd0;
            res_valid <= 1'b0;
            res_data  <= 8'h00;
            res_dst   <= 2'd0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_ld) begin
                            regs[cmd_dst] <= cmd_imm;
                            res_data      <= cmd_imm;
                            res_dst       <= cmd_dst;
                            res_err       <= 1'b0;
                            res_valid     <= 1'b1;
                        end else if (cmd_op <= OP_MAX) begin
                            alu_a     <= regs[cmd_sa];
                            alu_b     <= regs[cmd_sb];
                            alu_opsel <= cmd_op;
                            dst_q     <= cmd_dst;
                        end else begin
                            res_data  <= 8'h00;
                            res_dst   <= cmd_dst;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    regs[dst_q] <= alu_f;
                    res_data    <= alu_f;
                    res_dst     <= dst_q;
                    res_err     <= 1'b0;
                    res_valid   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
